// File: rtl/r5fp_mul_arb.sv
// rtl/r5fp_mul_arb.sv - two-port round-robin arbiter for a shared fixed-latency FP multiplier
// Credit-gated issue, LAT-deep shadow pipe and per-port result FIFOs.
module r5fp_mul_arb #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  localparam int W    = EXP_W + SIG_W + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [2*W-1:0] req_a_i,
  input  logic [2*W-1:0] req_b_i,
  input  logic [5:0]     req_rnd_i,
  output logic           mul_valid_o,
  output logic [W-1:0]   mul_a_o,
  output logic [W-1:0]   mul_b_o,
  output logic [2:0]     mul_rnd_o,
  input  logic [W-1:0]   dp_z_i,
  input  logic [7:0]     dp_status_i,
  output logic [1:0]     res_valid_o,
  input  logic [1:0]     res_ready_i,
  output logic [2*W-1:0] res_z_o,
  output logic [15:0]    res_status_o,
  output logic           busy_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = W + 8;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [CW-1:0] fcnt_q [2];
  logic [CW-1:0] fcnt_d [2];
  logic [CW-1:0] infl_q [2];
  logic [CW-1:0] infl_d [2];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [FW-1:0] mem_q [2][DEPTH];

  logic           rr_q, port_q, mul_valid_q;
  logic [W-1:0]   mul_a_q, mul_b_q;
  logic [2:0]     mul_rnd_q;
  logic [LAT-1:0] sv_q, sp_q;

  logic [1:0]   elig, grant, push, pop;
  logic         gnt_any, gnt_port, cap, cap_port;
  logic [W-1:0] sel_a, sel_b;
  logic [2:0]   sel_rnd;

  always_comb begin
    elig     = '0;
    push     = '0;
    pop      = '0;
    cap      = sv_q[LAT-1];
    cap_port = sp_q[LAT-1];
    for (int i = 0; i < 2; i++) begin
      // Credit uses registered counts only, so a pop frees a slot one cycle later.
      elig[i]   = req_valid_i[i] && (({1'b0, fcnt_q[i]} + {1'b0, infl_q[i]}) < DEPTH_C);
      push[i]   = cap && (cap_port == 1'(i));
      pop[i]    = res_ready_i[i] && (fcnt_q[i] != '0);
    end
    gnt_any  = |elig;
    gnt_port = (elig == 2'b11) ? ~rr_q : elig[1];
    grant    = gnt_any ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;
    sel_a    = gnt_port ? req_a_i[W +: W] : req_a_i[0 +: W];
    sel_b    = gnt_port ? req_b_i[W +: W] : req_b_i[0 +: W];
    sel_rnd  = gnt_port ? req_rnd_i[5:3] : req_rnd_i[2:0];
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = fcnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      infl_d[i] = infl_q[i] + CW'(grant[i]) - CW'(push[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= 1'b0;
      port_q      <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_rnd_q   <= '0;
      sv_q        <= '0;
      sp_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i]   <= '0;
        infl_q[i]   <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      mul_valid_q <= gnt_any;
      if (gnt_any) begin
        rr_q      <= gnt_port;
        port_q    <= gnt_port;
        mul_a_q   <= sel_a;
        mul_b_q   <= sel_b;
        mul_rnd_q <= sel_rnd;
      end
      // Shadow pipe mirrors the datapath so the last stage lines up with dp_z.
      sv_q[0] <= mul_valid_q;
      sp_q[0] <= port_q;
      for (int k = 1; k < LAT; k++) begin
        sv_q[k] <= sv_q[k-1];
        sp_q[k] <= sp_q[k-1];
      end
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= fcnt_d[i];
        infl_q[i] <= infl_d[i];
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {dp_status_i, dp_z_i};
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push[0] && fcnt_q[0] == DEPTH_C[CW-1:0]));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push[1] && fcnt_q[1] == DEPTH_C[CW-1:0]));

  always_comb begin
    res_z_o      = '0;
    res_status_o = '0;
    res_valid_o  = '0;
    for (int i = 0; i < 2; i++) begin
      res_valid_o[i] = (fcnt_q[i] != '0);
      if (fcnt_q[i] != '0) begin
        res_z_o[i*W +: W]      = mem_q[i][rd_ptr_q[i]][W-1:0];
        res_status_o[i*8 +: 8] = mem_q[i][rd_ptr_q[i]][FW-1:W];
      end
    end
  end

  assign req_ready_o = grant;
  assign mul_valid_o = mul_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_rnd_o   = mul_rnd_q;
  assign busy_o      = (infl_q[0] != '0) || (infl_q[1] != '0) || (fcnt_q[0] != '0) || (fcnt_q[1] != '0);
endmodule

// File: tb/tb_r5fp_mul_arb.sv
// tb/tb_r5fp_mul_arb.sv - directed bench for r5fp_mul_arb with a behavioural datapath
// Datapath stand-in: 1.0 * x = x, otherwise a mixing tag; status from operand bytes.
module tb_r5fp_mul_arb;
  localparam int EXP_W = 8, SIG_W = 23, LAT = 3, DEPTH = 4, W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid, req_ready, res_valid, res_ready;
  logic [63:0] req_a, req_b, res_z;
  logic [5:0]  req_rnd;
  logic        mul_valid, busy;
  logic [31:0] mul_a, mul_b, dp_z;
  logic [2:0]  mul_rnd;
  logic [7:0]  dp_status;
  logic [15:0] res_status;

  r5fp_mul_arb #(.EXP_W(EXP_W), .SIG_W(SIG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_rnd_i(req_rnd),
    .mul_valid_o(mul_valid), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_rnd_o(mul_rnd),
    .dp_z_i(dp_z), .dp_status_i(dp_status),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_z_o(res_z), .res_status_o(res_status), .busy_o(busy)
  );

  logic [31:0] m_a [LAT];
  logic [31:0] m_b [LAT];
  always @(posedge clk) begin
    m_a[0] <= mul_a;
    m_b[0] <= mul_b;
    for (int k = 1; k < LAT; k++) begin
      m_a[k] <= m_a[k-1];
      m_b[k] <= m_b[k-1];
    end
  end

  function automatic logic [31:0] dp_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000) return b;
    if (b == 32'h3F800000) return a;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  assign dp_z      = dp_f(m_a[LAT-1], m_b[LAT-1]);
  assign dp_status = m_a[LAT-1][7:0] ^ m_b[LAT-1][31:24] ^ 8'h3C;

  int n_chk = 0, n_pass = 0;
  logic [31:0] last_z;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic [31:0] z;
    logic [7:0]  st;
  } vec_t;
  vec_t tv[5];

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; res_ready = '0; req_a = '0; req_b = '0; req_rnd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int got, lat;
    @(posedge clk); #1;
    req_a[v.port*32 +: 32] = v.a;
    req_b[v.port*32 +: 32] = v.b;
    req_rnd[v.port*3 +: 3] = v.rnd;
    req_valid[v.port]      = 1'b1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[v.port]) begin got = 1; break; end
    end
    chk("vec_handshake", got, 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("vec_mul_valid", mul_valid, 1);
    chk("vec_mul_a", mul_a, v.a);
    chk("vec_mul_rnd", mul_rnd, v.rnd);
    lat = 1;
    while (!res_valid[v.port] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", lat, LAT + 2);
    chk("vec_res_z", res_z[v.port*32 +: 32], v.z);
    chk("vec_res_status", res_status[v.port*8 +: 8], v.st);
    last_z = res_z[v.port*32 +: 32];
    res_ready[v.port] = 1'b1;
    @(posedge clk); #1;
    res_ready = '0;
    @(negedge clk);
    chk("vec_drained", res_valid, 2'b00);
    chk("vec_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hs, r, p0, p1, c0, c1, bad, w;
    tv[0] = '{0, 32'h3F800000, 32'h40000000, 3'd0, 32'h40000000, 8'h7C};
    tv[1] = '{1, 32'h7FC00000, 32'h3F800000, 3'd1, 32'h7FC00000, 8'h03};
    tv[2] = '{0, 32'h12345678, 32'h3F800000, 3'd2, 32'h12345678, 8'h7B};
    tv[3] = '{1, 32'h40400000, 32'h40800000, 3'd3, 32'h40404080, 8'h7C};
    tv[4] = '{0, 32'hC0000000, 32'h3F800000, 3'd4, 32'hC0000000, 8'h03};

    do_reset();
    chk("rst_res_valid", res_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mul_valid", mul_valid, 1'b0);
    chk("rst_mul_a", mul_a, 32'h0);
    chk("rst_req_ready", req_ready, 2'b00);

    for (int i = 0; i < 5; i++) begin
      run_vec(tv[i]);
      if (i == 1) begin
        chk("nan_exp", last_z[30:23], 8'hFF);
        chk("nan_sig", (last_z[22:0] != 23'd0), 1'b1);
      end
    end

    // Both ports hammering: grants alternate starting with port 1.
    do_reset();
    @(posedge clk); #1;
    res_ready = 2'b11;
    req_a = {32'h3F800000, 32'h3F800000};
    req_b = {32'h40400000, 32'h40000000};
    req_valid = 2'b11;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      c0 += int'(res_valid[0]);
      c1 += int'(res_valid[1]);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c0 += int'(res_valid[0]);
      c1 += int'(res_valid[1]);
    end
    chk("rr_results_p0", c0, 4);
    chk("rr_results_p1", c1, 4);
    chk("rr_idle", busy, 1'b0);

    // Port 0 alone with no pops: exactly DEPTH handshakes.
    do_reset();
    @(posedge clk); #1;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    req_valid = 2'b01;
    hs = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      r = int'(req_ready[0]);
      @(posedge clk); #1;
      if (r != 0) begin hs++; req_b[31:0] = 32'h40000000 + 32'(hs); end
    end
    chk("credit_handshakes", hs, DEPTH);
    @(negedge clk);
    chk("credit_blocked", req_ready, 2'b00);
    chk("credit_head", res_z[31:0], 32'h40000000);
    res_ready[0] = 1'b1;
    #1;
    chk("credit_pop_same_cycle", req_ready, 2'b00);
    @(posedge clk); #1;
    res_ready = '0;
    @(negedge clk);
    chk("credit_pop_next_cycle", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      w = 0;
      while (!res_valid[0] && w < 20) begin @(negedge clk); w++; end
      chk("order_p0", res_z[31:0], 32'h40000000 + 32'(k));
      res_ready[0] = 1'b1;
      @(posedge clk); #1;
      res_ready = '0;
      @(negedge clk);
    end
    chk("order_p0_empty", res_valid, 2'b00);

    // Port 1 out of credit must not block port 0 nor overflow.
    do_reset();
    @(posedge clk); #1;
    req_a[63:32] = 32'h3F800000;
    req_b[63:32] = 32'h41000000;
    req_valid = 2'b10;
    hs = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      r = int'(req_ready[1]);
      @(posedge clk); #1;
      if (r != 0) begin hs++; req_b[63:32] = 32'h41000000 + 32'(hs); end
    end
    chk("p1_fill", hs, DEPTH);
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    req_valid = 2'b11;
    res_ready = 2'b01;
    p0 = 0; p1 = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      p0 += int'(req_ready[0]);
      p1 += int'(req_ready[1]);
    end
    chk("p1_starved", p1, 0);
    chk("p0_served", (p0 >= 3), 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (12) @(posedge clk);
    #1;
    res_ready = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("p1_fifo", res_z[63:32], 32'h41000000 + 32'(k));
      res_ready[1] = 1'b1;
      @(posedge clk); #1;
      res_ready = '0;
    end
    @(negedge clk);
    chk("p1_empty", res_valid, 2'b00);
    chk("p1_idle", busy, 1'b0);

    // Reset with three ops in flight: their results must be dropped.
    do_reset();
    @(posedge clk); #1;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h55AA0000;
    req_valid = 2'b01;
    repeat (3) begin
      @(posedge clk); #1;
      req_b[31:0] = req_b[31:0] + 32'd1;
    end
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mul_valid", mul_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (res_valid != 2'b00 || res_z != 64'h0 || busy) bad++;
    end
    chk("midrst_dropped", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
